// File: rtl/krp8_mem_arbiter_if.sv
// Core-side bus of the KRP8 unified-memory arbiter: instruction read port and data read/write port.
// The master modport is the core; the slave modport is the arbiter.
interface krp8_mem_arbiter_if;
    logic        ireq;
    logic [29:0] iaddr;
    logic        ignt;
    logic [31:0] instr;
    logic        ivalid;
    logic        dreq;
    logic        ndrw;
    logic [29:0] daddr;
    logic [31:0] dwdata;
    logic        dgnt;
    logic [31:0] drdata;
    logic        drvalid;

    modport master (
        output ireq, iaddr, dreq, ndrw, daddr, dwdata,
        input  ignt, instr, ivalid, dgnt, drdata, drvalid
    );

    modport slave (
        input  ireq, iaddr, dreq, ndrw, daddr, dwdata,
        output ignt, instr, ivalid, dgnt, drdata, drvalid
    );
endinterface

// File: rtl/krp8_mem_arbiter.sv
// Shares one single-port write-first SRAM between the KRP8 instruction and data ports.
// Define KRP8_ARB_PERFCNT_EN to add the conflict_cnt / starve_cnt performance counters.
module krp8_mem_arbiter #(
    parameter int unsigned AW         = 10,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    krp8_mem_arbiter_if.slave   core,
    output logic                m_csn,
    output logic [AW-1:0]       m_a,
    output logic                m_wen,
    output logic [31:0]         m_di,
    input  logic [31:0]         m_dout
`ifdef KRP8_ARB_PERFCNT_EN
    ,
    output logic [15:0]         conflict_cnt,
    output logic [15:0]         starve_cnt
`endif
);

    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    typedef enum logic [1:0] {TagNone, TagIRd, TagDRd} tag_e;

    tag_e       tag_q, tag_d;
    logic [3:0] starve_q, starve_d;
    logic       ignt, dgnt;
    logic       forced;

    // Grants are gated by rst_n so the SRAM sees no access while reset is held.
    always_comb begin
        ignt   = 1'b0;
        dgnt   = 1'b0;
        forced = 1'b0;
        if (rst_n) begin
            if (core.ireq && (!core.dreq || starve_q == StarveMax)) begin
                ignt   = 1'b1;
                forced = core.dreq;
            end else if (core.dreq) begin
                dgnt = 1'b1;
            end
        end
    end

    always_comb begin
        m_csn = ~(ignt | dgnt);
        m_wen = ~(dgnt & ~core.ndrw);
        m_a   = '0;
        if (ignt) begin
            m_a = core.iaddr[AW+1:2];
        end else if (dgnt) begin
            m_a = core.daddr[AW+1:2];
        end
        m_di = rst_n ? core.dwdata : 32'h0;
    end

    always_comb begin
        starve_d = starve_q;
        if (!core.ireq || ignt) begin
            starve_d = '0;
        end else if (starve_q != StarveMax) begin
            starve_d = starve_q + 4'd1;
        end

        tag_d = TagNone;
        if (ignt) begin
            tag_d = TagIRd;
        end else if (dgnt && core.ndrw) begin
            tag_d = TagDRd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q    <= TagNone;
            starve_q <= '0;
        end else begin
            tag_q    <= tag_d;
            starve_q <= starve_d;
        end
    end

    // SRAM output is shared; only the valid flags say whose word it is.
    assign core.ignt    = ignt;
    assign core.dgnt    = dgnt;
    assign core.instr   = m_dout;
    assign core.drdata  = m_dout;
    assign core.ivalid  = (tag_q == TagIRd);
    assign core.drvalid = (tag_q == TagDRd);

    logic unused_addr_bits;
    assign unused_addr_bits = ^{core.iaddr[29:AW+2], core.iaddr[1:0],
                                core.daddr[29:AW+2], core.daddr[1:0]};

`ifdef KRP8_ARB_PERFCNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt <= '0;
            starve_cnt   <= '0;
        end else begin
            if (core.ireq && core.dreq && conflict_cnt != 16'hFFFF) begin
                conflict_cnt <= conflict_cnt + 16'd1;
            end
            if (forced && starve_cnt != 16'hFFFF) begin
                starve_cnt <= starve_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
